instruction_cache_responder: RTL and testbench

Direct-mapped, block-organised instruction cache that answers the fetch unit's block requests and refills missing lines from backing memory. Each line holds four consecutive instructions (one fetch block); hits return the whole block combinationally in the same cycle, misses run a request/beat refill sequence. It sits between the instruction-fetch queue's ROM/cache port and the instruction memory bus.

---
 rtl/instruction_cache_responder_if.sv | 28 ++
 rtl/instruction_cache_responder.sv | 136 +++++++++++++
 tb/tb_instruction_cache_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_responder_if.sv
// Fetch-side block request/response and instruction-memory refill bus
// of the direct-mapped instruction cache.
interface instruction_cache_responder_if #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32
);
   logic [ADDRESS_WIDTH-1:0]  PC_in;
   logic                      Rd_en;
   logic                      Abort;
   logic [4*DATA_WIDTH-1:0]   Dout;
   logic                      Dout_valid;
   logic                      mem_req;
   logic [ADDRESS_WIDTH-1:0]  mem_addr;
   logic                      mem_ack;
   logic                      mem_rvalid;
   logic [DATA_WIDTH-1:0]     mem_rdata;

   // master: fetch unit plus instruction memory; slave: the cache
   modport master (
      output PC_in, Rd_en, Abort, mem_ack, mem_rvalid, mem_rdata,
      input  Dout, Dout_valid, mem_req, mem_addr
   );

   modport slave (
      input  PC_in, Rd_en, Abort, mem_ack, mem_rvalid, mem_rdata,
      output Dout, Dout_valid, mem_req, mem_addr
   );
endinterface

// File: rtl/instruction_cache_responder.sv
// Direct-mapped 4-word-block instruction cache with request/beat refill.
// Define ICACHE_PERF_CNT_EN to build the hit/miss performance counters.
module instruction_cache_responder #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned INDEX_WIDTH   = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   instruction_cache_responder_if.slave   bus,
   output logic [31:0]                    hit_count,
   output logic [31:0]                    miss_count
);
   localparam int unsigned LINES     = 1 << INDEX_WIDTH;
   localparam int unsigned TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH - 2;

   typedef enum logic [1:0] {IDLE, REQ, FILL, DRAIN} state_t;
   typedef logic [3:0][DATA_WIDTH-1:0] line_t;

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]               beat_q, beat_d;
   logic [2:0][DATA_WIDTH-1:0] buf_q, buf_d;

   logic [LINES-1:0]         valid_q;
   logic [TAG_WIDTH-1:0]     tag_q  [LINES];
   line_t                    data_q [LINES];

   logic [INDEX_WIDTH-1:0]   idx, fill_idx;
   logic [TAG_WIDTH-1:0]     tag, fill_tag;
   logic                     hit, line_we;
   logic                     unused_pc_bits;

   assign idx            = bus.PC_in[INDEX_WIDTH+1:2];
   assign tag            = bus.PC_in[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
   assign fill_idx       = addr_q[INDEX_WIDTH+1:2];
   assign fill_tag       = addr_q[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
   assign unused_pc_bits = ^bus.PC_in[1:0];

   assign hit = bus.Rd_en && !bus.Abort && (state_q == IDLE) &&
                valid_q[idx] && (tag_q[idx] == tag);

   assign bus.Dout_valid = hit;
   assign bus.Dout       = hit ? data_q[idx] : '0;
   assign bus.mem_req    = (state_q == REQ);
   assign bus.mem_addr   = addr_q;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      beat_d  = beat_q;
      buf_d   = buf_q;
      line_we = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.Rd_en && !bus.Abort && !hit) begin
               state_d = REQ;
               addr_d  = {bus.PC_in[ADDRESS_WIDTH-1:2], 2'b00};
               beat_d  = '0;
            end
         end
         REQ: begin
            if (bus.mem_ack)    state_d = bus.Abort ? DRAIN : FILL;
            else if (bus.Abort) state_d = IDLE;
         end
         FILL: begin
            if (bus.mem_rvalid) begin
               beat_d = beat_q + 2'd1;
               unique case (beat_q)
                  2'd0:    buf_d[0] = bus.mem_rdata;
                  2'd1:    buf_d[1] = bus.mem_rdata;
                  2'd2:    buf_d[2] = bus.mem_rdata;
                  default: ;
               endcase
            end
            // A beat arriving with Abort is still consumed; if it was the last one there is nothing left to drain
            if (bus.Abort)
               state_d = (bus.mem_rvalid && beat_q == 2'd3) ? IDLE : DRAIN;
            else if (bus.mem_rvalid && beat_q == 2'd3) begin
               line_we = 1'b1;
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (bus.mem_rvalid) begin
               beat_d = beat_q + 2'd1;
               if (beat_q == 2'd3) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         beat_q  <= '0;
         buf_q   <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         beat_q  <= beat_d;
         buf_q   <= buf_d;
         if (line_we) valid_q[fill_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (line_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= {bus.mem_rdata, buf_q};
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (state_q == IDLE && state_d == REQ) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif
endmodule

// File: tb/tb_instruction_cache_responder.sv
// Directed self-checking bench for instruction_cache_responder.
module tb_instruction_cache_responder;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] hit_count, miss_count;
   int          checks = 0;
   int          passes = 0;

   instruction_cache_responder_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

   instruction_cache_responder #(
      .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .INDEX_WIDTH(4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus.slave),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

`ifdef ICACHE_PERF_CNT_EN
   localparam logic [31:0] EXP_HITS = 32'd3, EXP_MISSES = 32'd1;
`else
   localparam logic [31:0] EXP_HITS = 32'd0, EXP_MISSES = 32'd0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a lookup that is expected to launch a refill; leaves the DUT in REQ
   task automatic launch(input logic [31:0] addr);
      bus.PC_in = addr;
      bus.Rd_en = 1'b1;
      tick();
      bus.Rd_en = 1'b0;
   endtask

   // Immediate ack and four back-to-back beats; leaves the DUT in IDLE
   task automatic refill(input logic [31:0] w0, w1, w2, w3);
      logic [31:0] w [4];
      w = '{w0, w1, w2, w3};
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = w[k];
         tick();
      end
      bus.mem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.PC_in = '0; bus.Rd_en = 0; bus.Abort = 0;
      bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (bus.Dout_valid !== 1'b0) $display("FAIL reset_dv: got %b want 0", bus.Dout_valid); else passes++;
      checks++; if (bus.Dout !== '0) $display("FAIL reset_dout: got %h want 0", bus.Dout); else passes++;
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.mem_req); else passes++;
      checks++; if (bus.mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", bus.mem_addr); else passes++;
      checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0)
         $display("FAIL reset_cnt: got %h/%h want 0/0", hit_count, miss_count); else passes++;
   endtask

   // Refill followed by same-cycle read of the cached counters (1 miss, 3 hit cycles)
   task automatic test_miss_refill();
      bus.PC_in = 32'h10; bus.Rd_en = 1'b1;
      #1;
      checks++; if (bus.Dout_valid !== 1'b0) $display("FAIL miss_dv: got %b want 0", bus.Dout_valid); else passes++;
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL miss_req_early: got %b want 0", bus.mem_req); else passes++;
      tick();
      bus.Rd_en = 1'b0;
      checks++; if (bus.mem_req !== 1'b1) $display("FAIL miss_req: got %b want 1", bus.mem_req); else passes++;
      checks++; if (bus.mem_addr !== 32'h10) $display("FAIL miss_addr: got %h want 10", bus.mem_addr); else passes++;
      refill(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL fill_req_done: got %b want 0", bus.mem_req); else passes++;
      bus.PC_in = 32'h12; bus.Rd_en = 1'b1;
      tick(); tick(); tick();
      bus.Rd_en = 1'b0;
      checks++; if (hit_count !== EXP_HITS) $display("FAIL hit_count: got %0d want %0d", hit_count, EXP_HITS); else passes++;
      checks++; if (miss_count !== EXP_MISSES) $display("FAIL miss_count: got %0d want %0d", miss_count, EXP_MISSES); else passes++;
      bus.Rd_en = 1'b1;
      #1;
      checks++; if (bus.Dout_valid !== 1'b1) $display("FAIL hit_dv: got %b want 1", bus.Dout_valid); else passes++;
      checks++; if (bus.Dout !== 128'h000000A3_000000A2_000000A1_000000A0)
         $display("FAIL hit_dout: got %h want 000000a3000000a2000000a1000000a0", bus.Dout); else passes++;
      bus.Abort = 1'b1;
      #1;
      checks++; if (bus.Dout_valid !== 1'b0) $display("FAIL abort_masks_hit: got %b want 0", bus.Dout_valid); else passes++;
      bus.Abort = 1'b0; bus.Rd_en = 1'b0;
      #1;
      checks++; if (bus.Dout_valid !== 1'b0 || bus.Dout !== '0)
         $display("FAIL idle_dout: got %b/%h want 0/0", bus.Dout_valid, bus.Dout); else passes++;
   endtask

   // 0x50 shares index 4 with 0x10; an un-acked request to 0x10 is withdrawn with Abort
   task automatic test_conflict_abort_req();
      launch(32'h50);
      checks++; if (bus.mem_addr !== 32'h50) $display("FAIL conf_addr: got %h want 50", bus.mem_addr); else passes++;
      refill(32'hB0, 32'hB1, 32'hB2, 32'hB3);
      bus.PC_in = 32'h53; bus.Rd_en = 1'b1;
      #1;
      checks++; if (bus.Dout !== 128'h000000B3_000000B2_000000B1_000000B0 || bus.Dout_valid !== 1'b1)
         $display("FAIL conf_hit: got %b/%h want 1/b3b2b1b0 block", bus.Dout_valid, bus.Dout); else passes++;
      bus.PC_in = 32'h10;
      #1;
      checks++; if (bus.Dout_valid !== 1'b0) $display("FAIL conf_evicted: got %b want 0", bus.Dout_valid); else passes++;
      tick();
      bus.Rd_en = 1'b0;
      checks++; if (bus.mem_req !== 1'b1) $display("FAIL conf_req: got %b want 1", bus.mem_req); else passes++;
      bus.Abort = 1'b1;
      tick();
      bus.Abort = 1'b0;
      checks++; if (bus.mem_req !== 1'b0) $display("FAIL abort_req: got %b want 0", bus.mem_req); else passes++;
      bus.PC_in = 32'h50; bus.Rd_en = 1'b1;
      #1;
      checks++; if (bus.Dout_valid !== 1'b1) $display("FAIL abort_req_idle: got %b want 1", bus.Dout_valid); else passes++;
      bus.Rd_en = 1'b0;
   endtask

   task automatic test_abort_fill();
      launch(32'h10);
      bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hC0; tick();
      bus.mem_rdata = 32'hC1; tick();
      bus.mem_rvalid = 1'b0; bus.Abort = 1'b1; tick(); bus.Abort = 1'b0;
      bus.PC_in = 32'h50; bus.Rd_en = 1'b1;
      #1;
      checks++; if (bus.Dout_valid !== 1'b0 || bus.mem_req !== 1'b0)
         $display("FAIL drain_busy: got dv=%b req=%b want 0/0", bus.Dout_valid, bus.mem_req); else passes++;
      bus.Rd_en = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hC2; tick();
      bus.mem_rdata = 32'hC3; tick();
      bus.mem_rvalid = 1'b0;
      bus.PC_in = 32'h10; bus.Rd_en = 1'b1;
      #1;
      checks++; if (bus.Dout_valid !== 1'b0) $display("FAIL drain_no_write: got %b want 0", bus.Dout_valid); else passes++;
      bus.PC_in = 32'h50;
      #1;
      checks++; if (bus.Dout_valid !== 1'b1 || bus.Dout !== 128'h000000B3_000000B2_000000B1_000000B0)
         $display("FAIL drain_keep_old: got %b/%h want 1/b-block", bus.Dout_valid, bus.Dout); else passes++;
      bus.Rd_en = 1'b0;
   endtask

   task automatic test_last_beat_lookup();
      launch(32'h10);
      bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata = 32'hD0; tick();
      bus.mem_rdata = 32'hD1; tick();
      bus.mem_rdata = 32'hD2; tick();
      bus.mem_rdata = 32'hD3; bus.PC_in = 32'h10; bus.Rd_en = 1'b1;
      #1;
      checks++; if (bus.Dout_valid !== 1'b0) $display("FAIL lastbeat_dv: got %b want 0", bus.Dout_valid); else passes++;
      tick();
      bus.mem_rvalid = 1'b0;
      checks++; if (bus.Dout_valid !== 1'b1 || bus.Dout !== 128'h000000D3_000000D2_000000D1_000000D0)
         $display("FAIL lastbeat_next: got %b/%h want 1/d-block", bus.Dout_valid, bus.Dout); else passes++;
      bus.Rd_en = 1'b0;
      launch(32'h27);
      checks++; if (bus.mem_addr !== 32'h24) $display("FAIL align_addr: got %h want 24", bus.mem_addr); else passes++;
      refill(32'hE0, 32'hE1, 32'hE2, 32'hE3);
      bus.PC_in = 32'h25; bus.Rd_en = 1'b1;
      #1;
      checks++; if (bus.Dout !== 128'h000000E3_000000E2_000000E1_000000E0)
         $display("FAIL idx9_hit: got %h want e-block", bus.Dout); else passes++;
      bus.PC_in = 32'h11;
      #1;
      checks++; if (bus.Dout !== 128'h000000D3_000000D2_000000D1_000000D0)
         $display("FAIL idx4_kept: got %h want d-block", bus.Dout); else passes++;
      bus.Rd_en = 1'b0;
   endtask

   task automatic test_reset_mid_fill();
      launch(32'h30);
      bus.mem_ack = 1'b1; tick(); bus.mem_ack = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hF0; tick();
      bus.mem_rvalid = 1'b0;
      reset = 1'b1;
      #1;
      checks++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0)
         $display("FAIL rst_fill_async: got req=%b addr=%h want 0/0", bus.mem_req, bus.mem_addr); else passes++;
      tick();
      reset = 1'b0;
      bus.PC_in = 32'h10; bus.Rd_en = 1'b1;
      #1;
      checks++; if (bus.Dout_valid !== 1'b0) $display("FAIL rst_inval_10: got %b want 0", bus.Dout_valid); else passes++;
      bus.PC_in = 32'h24;
      #1;
      checks++; if (bus.Dout_valid !== 1'b0) $display("FAIL rst_inval_24: got %b want 0", bus.Dout_valid); else passes++;
      bus.Rd_en = 1'b0;
      checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0)
         $display("FAIL rst_cnt: got %h/%h want 0/0", hit_count, miss_count); else passes++;
   endtask

   initial begin
      test_reset();
      test_miss_refill();
      test_conflict_abort_req();
      test_abort_fill();
      test_last_beat_lookup();
      test_reset_mid_fill();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
